// File: rtl/cp0_exc_unit.sv
// rtl/cp0_exc_unit.sv - CP0 exception/interrupt responder (SR, Cause, EPC, PRId)
module cp0_exc_unit #(
    parameter logic [31:0] PRID    = 32'h2020_0707,
    parameter int          EXL_BIT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A1,
    input  logic [4:0]  A2,
    input  logic [31:0] DIn,
    input  logic        WE,
    input  logic [31:0] PC,
    input  logic        BD,
    input  logic [4:0]  ExcCodeIn,
    input  logic [5:0]  HWInt,
    input  logic        EXLClr,
    output logic        IntReq,
    output logic [31:0] EPCOut,
    output logic [31:0] DOut
);

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  code_q, code_d;
    logic [31:0] epc_q, epc_d;

    logic        int_pend;
    logic        exc_pend;
    logic [31:0] pc_al;
    logic [31:0] sr_rd;
    logic [31:0] cause_rd;

    assign int_pend = (|(HWInt & im_q)) & ie_q & ~exl_q;
    assign exc_pend = (ExcCodeIn != 5'd0) & ~exl_q;
    // Gate with reset so a pending ExcCodeIn cannot raise IntReq while in reset.
    assign IntReq   = (int_pend | exc_pend) & reset;
    assign pc_al    = {PC[31:2], 2'b00};

    always_comb begin
        im_d   = im_q;
        exl_d  = exl_q;
        ie_d   = ie_q;
        bd_d   = bd_q;
        ip_d   = HWInt;
        code_d = code_q;
        epc_d  = epc_q;
        if (IntReq) begin
            exl_d  = 1'b1;
            code_d = int_pend ? 5'd0 : ExcCodeIn;
            bd_d   = BD;
            epc_d  = BD ? (pc_al - 32'd4) : pc_al;
        end else begin
            if (WE && (A2 == 5'd12)) begin
                im_d  = DIn[15:10];
                exl_d = DIn[EXL_BIT];
                ie_d  = DIn[0];
            end
            if (WE && (A2 == 5'd14)) begin
                epc_d = {DIn[31:2], 2'b00};
            end
            // eret beats a simultaneous mtc0 SR on the EXL bit only.
            if (EXLClr) begin
                exl_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            im_q   <= 6'd0;
            exl_q  <= 1'b0;
            ie_q   <= 1'b0;
            bd_q   <= 1'b0;
            ip_q   <= 6'd0;
            code_q <= 5'd0;
            epc_q  <= 32'd0;
        end else begin
            im_q   <= im_d;
            exl_q  <= exl_d;
            ie_q   <= ie_d;
            bd_q   <= bd_d;
            ip_q   <= ip_d;
            code_q <= code_d;
            epc_q  <= epc_d;
        end
    end

    always_comb begin
        sr_rd          = 32'd0;
        sr_rd[15:10]   = im_q;
        sr_rd[EXL_BIT] = exl_q;
        sr_rd[0]       = ie_q;
    end

    assign cause_rd = {bd_q, 15'd0, ip_q, 3'd0, code_q, 2'b00};
    assign EPCOut   = epc_q;

    always_comb begin
        case (A1)
            5'd12:   DOut = sr_rd;
            5'd13:   DOut = cause_rd;
            5'd14:   DOut = epc_q;
            5'd15:   DOut = PRID;
            default: DOut = 32'd0;
        endcase
    end

endmodule

// File: tb/tb_cp0_exc_unit.sv
// tb/tb_cp0_exc_unit.sv - vector table and scoreboard bench for cp0_exc_unit
module tb_cp0_exc_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  A1, A2, ExcCodeIn;
    logic [31:0] DIn, PC;
    logic        WE, BD, EXLClr;
    logic [5:0]  HWInt;
    logic        IntReq;
    logic [31:0] EPCOut, DOut;

    cp0_exc_unit dut (
        .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
        .PC(PC), .BD(BD), .ExcCodeIn(ExcCodeIn), .HWInt(HWInt),
        .EXLClr(EXLClr), .IntReq(IntReq), .EPCOut(EPCOut), .DOut(DOut)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  a2;
        logic [31:0] din;
        logic        we;
        logic [31:0] pc;
        logic        bd;
        logic [4:0]  exc;
        logic [5:0]  hw;
        logic        clr;
        logic        irq;
        logic [31:0] sr;
        logic [31:0] cause;
        logic [31:0] epc;
    } vec_t;

    typedef struct {
        logic        irq;
        logic [31:0] sr;
        logic [31:0] cause;
        logic [31:0] epc;
    } exp_t;

    vec_t vecs[13];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [4:0] a2, input logic [31:0] din, input logic we,
                                input logic [31:0] pc, input logic bd, input logic [4:0] exc,
                                input logic [5:0] hw, input logic clr, input logic irq,
                                input logic [31:0] sr, input logic [31:0] cause,
                                input logic [31:0] epc);
        vec_t v;
        v.a2 = a2; v.din = din; v.we = we; v.pc = pc; v.bd = bd; v.exc = exc;
        v.hw = hw; v.clr = clr; v.irq = irq; v.sr = sr; v.cause = cause; v.epc = epc;
        return v;
    endfunction

    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        logic irq_seen;
        @(negedge clk);
        A2 = v.a2; DIn = v.din; WE = v.we; PC = v.pc; BD = v.bd;
        ExcCodeIn = v.exc; HWInt = v.hw; EXLClr = v.clr;
        e.irq = v.irq; e.sr = v.sr; e.cause = v.cause; e.epc = v.epc;
        sb.push_back(e);
        #1 irq_seen = IntReq;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk($sformatf("v%0d_sb_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk($sformatf("v%0d_intreq", idx), {31'd0, irq_seen}, {31'd0, e.irq});
            A1 = 5'd12; #1 chk($sformatf("v%0d_sr", idx), DOut, e.sr);
            A1 = 5'd13; #1 chk($sformatf("v%0d_cause", idx), DOut, e.cause);
            A1 = 5'd14; #1 chk($sformatf("v%0d_epc", idx), DOut, e.epc);
            chk($sformatf("v%0d_epcout", idx), EPCOut, e.epc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        //           a2     din            we   pc             bd   exc    hw      clr  irq  sr             cause          epc
        vecs[0]  = mk(5'd12, 32'h0000_0401, 1'b1, 32'h0,        1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 32'h0000_0401, 32'h0,         32'h0);
        vecs[1]  = mk(5'd0,  32'h0,         1'b0, 32'h0000_3008, 1'b0, 5'd0,  6'd1,  1'b0, 1'b1, 32'h0000_0403, 32'h0000_0400, 32'h0000_3008);
        vecs[2]  = mk(5'd0,  32'h0,         1'b0, 32'h0000_4000, 1'b0, 5'd10, 6'd1,  1'b0, 1'b0, 32'h0000_0403, 32'h0000_0400, 32'h0000_3008);
        vecs[3]  = mk(5'd0,  32'h0,         1'b0, 32'h0000_4000, 1'b0, 5'd0,  6'd0,  1'b1, 1'b0, 32'h0000_0401, 32'h0,         32'h0000_3008);
        vecs[4]  = mk(5'd0,  32'h0,         1'b0, 32'h0000_5004, 1'b0, 5'd10, 6'd0,  1'b0, 1'b1, 32'h0000_0403, 32'h0000_0028, 32'h0000_5004);
        vecs[5]  = mk(5'd12, 32'h0,         1'b1, 32'h0000_5008, 1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 32'h0,         32'h0000_0028, 32'h0000_5004);
        vecs[6]  = mk(5'd0,  32'h0,         1'b0, 32'h0000_3010, 1'b1, 5'd12, 6'd0,  1'b0, 1'b1, 32'h0000_0002, 32'h8000_0030, 32'h0000_300C);
        vecs[7]  = mk(5'd12, 32'h0000_FC03, 1'b1, 32'h0,        1'b0, 5'd0,  6'd0,  1'b1, 1'b0, 32'h0000_FC01, 32'h8000_0030, 32'h0000_300C);
        vecs[8]  = mk(5'd14, 32'hDEAD_BEEF, 1'b1, 32'h0000_6002, 1'b0, 5'd12, 6'd4,  1'b0, 1'b1, 32'h0000_FC03, 32'h0000_1000, 32'h0000_6000);
        vecs[9]  = mk(5'd12, 32'h0,         1'b1, 32'h0,        1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 32'h0,         32'h0,         32'h0000_6000);
        vecs[10] = mk(5'd14, 32'hDEAD_BEEF, 1'b1, 32'h0,        1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 32'h0,         32'h0,         32'hDEAD_BEEC);
        vecs[11] = mk(5'd13, 32'hFFFF_FFFF, 1'b1, 32'h0,        1'b0, 5'd0,  6'd0,  1'b0, 1'b0, 32'h0,         32'h0,         32'hDEAD_BEEC);
        vecs[12] = mk(5'd0,  32'h0,         1'b0, 32'h0,        1'b1, 5'd4,  6'd0,  1'b0, 1'b1, 32'h0000_0002, 32'h8000_0010, 32'hFFFF_FFFC);

        reset = 1'b0; A1 = 5'd12; A2 = 5'd0; DIn = 32'h0; WE = 1'b0; PC = 32'h0;
        BD = 1'b0; ExcCodeIn = 5'd5; HWInt = 6'd0; EXLClr = 1'b0;
        #12;
        chk("rst_intreq_low", {31'd0, IntReq}, 32'd0);
        A1 = 5'd15; #1 chk("rst_prid", DOut, 32'h2020_0707);
        @(negedge clk);
        ExcCodeIn = 5'd0; reset = 1'b1;
        #1;
        A1 = 5'd12; #1 chk("init_sr", DOut, 32'h0);
        A1 = 5'd13; #1 chk("init_cause", DOut, 32'h0);
        A1 = 5'd14; #1 chk("init_epc", DOut, 32'h0);
        A1 = 5'd15; #1 chk("init_prid", DOut, 32'h2020_0707);
        A1 = 5'd3;  #1 chk("init_unmapped", DOut, 32'h0);
        chk("init_intreq", {31'd0, IntReq}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            apply(vecs[i], i);
        end

        // Handler is active from the last vector; pull reset mid-cycle with an exception pending.
        @(negedge clk);
        WE = 1'b0; ExcCodeIn = 5'd9; HWInt = 6'd0; EXLClr = 1'b0;
        #1 chk("pre_rst_intreq_masked", {31'd0, IntReq}, 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("midrst_intreq", {31'd0, IntReq}, 32'd0);
        A1 = 5'd12; #1 chk("midrst_sr", DOut, 32'h0);
        A1 = 5'd13; #1 chk("midrst_cause", DOut, 32'h0);
        A1 = 5'd14; #1 chk("midrst_epc", DOut, 32'h0);
        chk("midrst_epcout", EPCOut, 32'h0);
        @(negedge clk);
        ExcCodeIn = 5'd0; reset = 1'b1;
        #1 chk("post_rst_intreq", {31'd0, IntReq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cp0_exc_unit.md
Name: cp0_exc_unit

Overview:
- Coprocessor-0 exception/interrupt responder. Sits in the M stage and consumes exception codes raised upstream, including the arithmetic-overflow flag from the execute-stage arithmetic unit, encoded as ExcCode 12 (Ov).
- Holds SR, Cause, EPC and PRId. Arbitrates interrupts against exceptions and raises IntReq to flush the pipeline and redirect fetch.
- Serves mfc0/mtc0/eret.

Parameters:
- PRID, 32'h2020_0707, read-only value returned for register 15.
- EXL_BIT, 1, bit position of EXL in SR. IE is bit 0; IM is SR[15:10].

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- A1  input  5  mfc0 read register number
- A2  input  5  mtc0 write register number
- DIn  input  32  mtc0 write data
- WE  input  1  mtc0 write enable
- PC  input  32  PC of the M-stage instruction
- BD  input  1  M-stage instruction is in a branch delay slot
- ExcCodeIn  input  5  M-stage exception code; 0 means none; 12 means Ov from the arithmetic unit
- HWInt  input  6  external interrupt lines, level-sensitive
- EXLClr  input  1  eret in M stage
- IntReq  output  1  take interrupt/exception this cycle
- EPCOut  output  32  current EPC, used as the eret target
- DOut  output  32  mfc0 read data

Behaviour:
- Reset (reset low, async):
  - SR=0, Cause=0, EPC=0.
  - IntReq forced 0 while reset is low.
  - DOut and EPCOut reflect the reset register values (0, or PRID for A1=15).
- Register map:
  - 12 SR: IM[15:10], EXL[1], IE[0]; other bits read 0.
  - 13 Cause: BD[31], IP[15:10], ExcCode[6:2]; other bits read 0.
  - 14 EPC.
  - 15 PRId.
  - Any other A1 reads 0.
- Reads: DOut is combinational from A1. There is no write-to-read bypass; the pipeline handles hazards.
- Cause.IP is sampled from HWInt on every clk edge, regardless of other events.
- Request logic (combinational):
  - int_pend = |(HWInt & SR.IM) & SR.IE & ~SR.EXL
  - exc_pend = (ExcCodeIn != 0) & ~SR.EXL
  - IntReq = int_pend | exc_pend
- Priority: interrupt over exception. The code taken is 0 if int_pend, else ExcCodeIn.
- On a clk edge with IntReq=1:
  - SR.EXL <= 1.
  - Cause.ExcCode <= taken code.
  - Cause.BD <= BD.
  - EPC <= BD ? {PC[31:2],2'b00}-4 : {PC[31:2],2'b00}. Subtraction is modulo 2^32, so PC=0 with BD=1 gives 32'hFFFF_FFFC.
  - Any mtc0 in the same cycle is discarded.
- mtc0, applied at the clk edge when WE=1 and IntReq=0:
  - A2=12: SR <= DIn masked to IM, EXL and IE.
  - A2=14: EPC <= {DIn[31:2],2'b00}.
  - A2=13, A2=15 and other addresses: writes ignored.
- EXLClr=1 at the clk edge: SR.EXL <= 0. A simultaneous IntReq cannot occur because EXL=1 masks it. If mtc0 to SR lands in the same cycle, the EXLClr clear of EXL wins; the other SR bits take DIn.
- While EXL=1:
  - Further exceptions and interrupts are ignored; IntReq=0.
  - The ExcCode, BD and EPC registers stay frozen.
- State summary:
  - NORMAL (EXL=0) -> HANDLER (EXL=1) on IntReq.
  - HANDLER -> NORMAL on EXLClr, or on mtc0 SR with DIn[1]=0.
- Reset asserted mid-handler returns to NORMAL with all registers cleared.

Test Plan:
- Reset low, then high; A1=12,13,14 -> DOut=0. A1=15 -> DOut=32'h2020_0707. IntReq=0.
- mtc0 SR=32'h0000_0401 (IM[10], IE); HWInt=6'b000001; PC=32'h0000_3008, BD=0 -> IntReq=1 that cycle. After the edge: EXL=1, Cause.ExcCode=0, Cause.IP=1, EPC=32'h0000_3008, IntReq=0.
- SR.IE=0; ExcCodeIn=12 (Ov); PC=32'h0000_3010, BD=1 -> IntReq=1. After the edge: Cause=32'h8000_0030 (BD set, ExcCode 12), EPC=32'h0000_300C.
- Same cycle: HWInt enabled, ExcCodeIn=12, WE=1, A2=14, DIn=32'hDEAD_BEEF -> ExcCode=0 (interrupt wins), EPC=PC (mtc0 dropped).
- In handler: ExcCodeIn=10 -> IntReq=0, registers unchanged. Then EXLClr=1 -> EXL=0. Next cycle with ExcCodeIn=10 -> IntReq=1.
- Assert reset low while EXL=1 mid-cycle -> SR, Cause, EPC=0 immediately without a clock edge; IntReq=0.
